// File: rtl/mux3_sched_pkg.sv
// Shared types, select encodings and round-robin helpers for the mux3 scheduler.
package mux3_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [1:0] SEL_U = 2'b00;
    localparam logic [1:0] SEL_V = 2'b01;
    localparam logic [1:0] SEL_W = 2'b10;

    localparam logic [1:0] IDX_U = 2'd0;
    localparam logic [1:0] IDX_V = 2'd1;
    localparam logic [1:0] IDX_W = 2'd2;

    // First set bit of req scanning last+1, last+2, last (mod 3); the previous owner ranks last.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] win;
        int         i;
        win = last;
        for (int k = 3; k >= 1; k--) begin
            i = (int'(last) + k) % 3;
            if (req[i]) win = 2'(i);
        end
        return win;
    endfunction

    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            IDX_U:   oh = 3'b001;
            IDX_V:   oh = 3'b010;
            IDX_W:   oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mux3_rr_scheduler_if.sv
// Requester/data bus between the board logic (master) and the scheduler (slave).
interface mux3_rr_scheduler_if;
    logic [2:0] req;
    logic [1:0] U;
    logic [1:0] V;
    logic [1:0] W;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic [1:0] M;
    logic       busy;

    modport master (output req, U, V, W, input gnt, sel, M, busy);
    modport slave  (input req, U, V, W, output gnt, sel, M, busy);
endinterface

// File: rtl/mux3_2bit.sv
// Combinational 2-bit 3-to-1 datapath; select 11 yields zero.
module mux3_2bit
    import mux3_sched_pkg::*;
(
    input  logic [1:0] U,
    input  logic [1:0] V,
    input  logic [1:0] W,
    input  logic [1:0] sel,
    output logic [1:0] y
);

    always_comb begin
        y = 2'b00;
        case (sel)
            SEL_U:   y = U;
            SEL_V:   y = V;
            SEL_W:   y = W;
            default: y = 2'b00;
        endcase
    end

endmodule

// File: rtl/mux3_rr_scheduler.sv
// Round-robin owner of the shared 2-bit 3-to-1 mux for requesters U, V, W.
// Optional dwell-limit preemption is enabled by defining MUX_SCHED_DWELL_EN.
module mux3_rr_scheduler
    import mux3_sched_pkg::*;
#(
    parameter int DWELL = 4
)(
    input  logic                 CLOCK_50,
    input  logic                 reset,
    mux3_rr_scheduler_if.slave   bus
);

    if (DWELL < 1 || DWELL > 255) begin : g_dwell_range
        $error("DWELL must be in 1..255");
    end

    state_t     state;
    logic [2:0] gnt_q;
    logic [1:0] sel_q;
    logic       busy_q;
    logic [1:0] last;
    logic [1:0] mux_y;

    logic       owner_req;
    logic [1:0] win_any;

    // In GRANT, last always names the current owner.
    assign owner_req = |(bus.req & idx_onehot(last));
    assign win_any   = rr_pick(bus.req, last);

`ifdef MUX_SCHED_DWELL_EN
    localparam int             CW  = $clog2(DWELL + 1);
    localparam logic [CW-1:0]  LIM = CW'(DWELL - 1);
    localparam logic [CW-1:0]  SAT = CW'(DWELL);

    logic [CW-1:0] cnt;
    logic [2:0]    others;
    logic [1:0]    win_oth;

    assign others  = bus.req & ~idx_onehot(last);
    assign win_oth = rr_pick(others, last);
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state  <= IDLE;
            gnt_q  <= 3'b000;
            sel_q  <= SEL_U;
            busy_q <= 1'b0;
            last   <= IDX_W;
`ifdef MUX_SCHED_DWELL_EN
            cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state  <= GRANT;
                        gnt_q  <= idx_onehot(win_any);
                        sel_q  <= win_any;
                        busy_q <= 1'b1;
                        last   <= win_any;
`ifdef MUX_SCHED_DWELL_EN
                        cnt    <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!owner_req) begin
                        // Release and re-arbitrate on the same edge: no bubble.
                        if (|bus.req) begin
                            gnt_q <= idx_onehot(win_any);
                            sel_q <= win_any;
                            last  <= win_any;
`ifdef MUX_SCHED_DWELL_EN
                            cnt   <= '0;
`endif
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= 3'b000;
                            sel_q  <= SEL_U;
                            busy_q <= 1'b0;
                        end
                    end
`ifdef MUX_SCHED_DWELL_EN
                    // >= so a requester arriving after saturation still preempts next edge.
                    else if (cnt >= LIM && |others) begin
                        gnt_q <= idx_onehot(win_oth);
                        sel_q <= win_oth;
                        last  <= win_oth;
                        cnt   <= '0;
                    end else if (cnt != SAT) begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= 3'b000;
                    sel_q  <= SEL_U;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    mux3_2bit u_mux (
        .U   (bus.U),
        .V   (bus.V),
        .W   (bus.W),
        .sel (sel_q),
        .y   (mux_y)
    );

    assign bus.gnt  = gnt_q;
    assign bus.sel  = sel_q;
    assign bus.busy = busy_q;
    assign bus.M    = busy_q ? mux_y : 2'b00;

endmodule

// File: tb/tb_mux3_rr_scheduler.sv
// Self-checking bench for mux3_rr_scheduler: directed scenarios plus random traffic vs. a reference model.
module tb_mux3_rr_scheduler;

    localparam int DWELL = 4;
`ifdef MUX_SCHED_DWELL_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;

    mux3_rr_scheduler_if bus ();

    mux3_rr_scheduler #(.DWELL(DWELL)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: owner index (-1 = idle), last granted index, cycles owned so far.
    int m_owner = -1;
    int m_last  = 2;
    int m_held  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_after(input logic [2:0] r, input int from);
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (from + k) % 3;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [2:0] r, input logic rs);
        logic [2:0] rest;
        if (rs) begin
            m_owner = -1;
            m_last  = 2;
            m_held  = 0;
        end else if (m_owner < 0 || !r[m_owner]) begin
            m_owner = first_after(r, m_last);
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else begin
            rest = r & ~(3'b001 << m_owner);
            if (DWELL_EN && m_held >= DWELL && rest != 3'b000) begin
                m_owner = first_after(rest, m_last);
                m_last  = m_owner;
                m_held  = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model();
        logic [2:0] e_gnt;
        logic [1:0] e_sel;
        logic [1:0] e_m;
        e_gnt = 3'b000;
        e_sel = 2'b00;
        e_m   = 2'b00;
        if (m_owner >= 0) begin
            e_gnt = 3'b001 << m_owner;
            e_sel = 2'(m_owner);
            e_m   = (m_owner == 0) ? bus.U : (m_owner == 1) ? bus.V : bus.W;
        end
        chk("gnt",  32'(bus.gnt),  32'(e_gnt));
        chk("sel",  32'(bus.sel),  32'(e_sel));
        chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("M",    32'(bus.M),    32'(e_m));
    endtask

    // Apply req/reset, clock once, advance the model, and compare just after the edge.
    task automatic cycle(input logic [2:0] r, input logic rs);
        bus.req = r;
        reset   = rs;
        @(posedge CLOCK_50);
        model_step(r, rs);
        #1;
        check_model();
    endtask

    logic [2:0] r;
    logic [2:0] exp_g;

    initial begin
        bus.req = 3'b000;
        bus.U   = 2'b01;
        bus.V   = 2'b10;
        bus.W   = 2'b11;

        // Reset with all requesting, then first grant goes to U.
        cycle(3'b111, 1'b1);
        cycle(3'b111, 1'b1);
        chk("rst_gnt",  32'(bus.gnt),  32'h0);
        chk("rst_sel",  32'(bus.sel),  32'h0);
        chk("rst_M",    32'(bus.M),    32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        cycle(3'b111, 1'b0);
        chk("first_gnt", 32'(bus.gnt), 32'h1);
        chk("first_sel", 32'(bus.sel), 32'h0);

        // Owner drops for one cycle on being granted: U, V, W, U with no idle.
        cycle(3'b111 & ~bus.gnt, 1'b0);
        chk("rr_V", 32'(bus.gnt), 32'h2);
        chk("rr_busy", 32'(bus.busy), 32'h1);
        cycle(3'b111 & ~bus.gnt, 1'b0);
        chk("rr_W", 32'(bus.gnt), 32'h4);
        cycle(3'b111 & ~bus.gnt, 1'b0);
        chk("rr_U", 32'(bus.gnt), 32'h1);

        // Datapath: V granted, M shows V's word.
        cycle(3'b000, 1'b1);
        cycle(3'b010, 1'b0);
        chk("dp_sel", 32'(bus.sel), 32'h1);
        chk("dp_M",   32'(bus.M),   32'h2);

        // V and W held high: alternate every DWELL cycles when dwell is enabled.
        cycle(3'b000, 1'b1);
        for (int i = 0; i < 16; i++) begin
            cycle(3'b110, 1'b0);
            if (DWELL_EN) exp_g = (((i / DWELL) % 2) == 0) ? 3'b010 : 3'b100;
            else          exp_g = 3'b010;
            chk("dwell_gnt", 32'(bus.gnt), 32'(exp_g));
        end

        // Sole requester never released.
        cycle(3'b000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(3'b001, 1'b0);
            chk("sole_gnt", 32'(bus.gnt), 32'h1);
        end

        // Mid-grant reset returns last to W, so U wins next.
        cycle(3'b000, 1'b1);
        cycle(3'b100, 1'b0);
        chk("mid_W", 32'(bus.gnt), 32'h4);
        cycle(3'b100, 1'b1);
        chk("mid_rst_gnt",  32'(bus.gnt),  32'h0);
        chk("mid_rst_busy", 32'(bus.busy), 32'h0);
        cycle(3'b101, 1'b0);
        chk("mid_U", 32'(bus.gnt), 32'h1);

        // Random traffic with sticky requests and occasional reset.
        r = 3'b000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            bus.U = 2'($urandom_range(0, 3));
            bus.V = 2'($urandom_range(0, 3));
            bus.W = 2'($urandom_range(0, 3));
            cycle(r, ($urandom_range(0, 59) == 0));
            chk("onehot", 32'($countones(bus.gnt) <= 1), 32'h1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
